test_monitor: RTL

Memory-mapped simulation/bring-up monitor that replaces fixed-cycle pass/fail checks with a software-driven verdict. Sits on the SoC data bus as a slave. Firmware logs failing tests, then writes a terminate word. A cycle watchdog bounds runtime. Testbenches and FPGA LEDs observe `done`/`pass`/`timeout` instead of hard-coding a cycle limit.

---
 rtl/test_monitor_pkg.sv | 30 +++
 rtl/sat_counter.sv | 27 ++
 rtl/test_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared definitions for the test_monitor slice.
//   - tm_state_e   : monitor state encoding (also reported in STATUS[4:3])
//   - TM_*_OFF     : byte offsets of the four registers (only bits [3:2] decode)
//   - TM_STAT_*    : bit positions inside the STATUS register
package test_monitor_pkg;

  typedef enum logic [1:0] {
    TM_RUN     = 2'd0,
    TM_PASS    = 2'd1,
    TM_FAIL    = 2'd2,
    TM_TIMEOUT = 2'd3
  } tm_state_e;

  localparam logic [3:0] TM_RESULT_OFF = 4'h0;
  localparam logic [3:0] TM_FAIL_OFF   = 4'h4;
  localparam logic [3:0] TM_CYCLE_OFF  = 4'h8;
  localparam logic [3:0] TM_STATUS_OFF = 4'hC;

  localparam int TM_STAT_DONE_BIT    = 0;
  localparam int TM_STAT_PASS_BIT    = 1;
  localparam int TM_STAT_TIMEOUT_BIT = 2;
  localparam int TM_STAT_STATE_LSB   = 3;
  localparam int TM_STAT_STATE_MSB   = 4;

  // Word index of a byte offset, matching how addr[3:2] is decoded.
  function automatic logic [1:0] tm_word(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : synchronous clear, has priority over en
//   en       : count enable
//   cnt      : current count, WIDTH bits
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/test_monitor.sv
// test_monitor: memory-mapped bring-up monitor. Firmware logs failures and
// then writes a terminate word to RESULT; the verdict is shown on done/pass/
// timeout. A cycle watchdog bounds the run when TEST_MONITOR_TIMEOUT_EN is
// defined; without that macro the monitor waits for a terminate forever and
// timeout stays 0 (the cycle counter still runs for CYCLE reads).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, rd_en        : single-cycle write / read strobes
//   addr[3:0]           : byte address, bits [3:2] select the register
//   wr_data             : write data (RESULT only)
//   rd_data             : registered read data, 1-cycle latency, holds
//   done, pass, timeout : verdict flags
//   fail_count          : saturating count of logged failures
//   exit_code           : wr_data[DATA_WIDTH-1:1] of the terminate write
// Registers: 0x0 RESULT (wo, reads 0), 0x4 FAIL_COUNT, 0x8 CYCLE,
//   0xC STATUS {state[1:0], timeout, pass, done}.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int FAIL_WIDTH = 16,
  parameter int MAX_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [3:0]            addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [FAIL_WIDTH-1:0] fail_count,
  output logic [DATA_WIDTH-2:0] exit_code
);

  tm_state_e             state, state_next;
  logic [CNT_WIDTH-1:0]  cycle_cnt;
  logic                  result_wr;
  logic                  term_wr;
  logic                  fail_wr;
  logic                  cyc_en;
  logic                  at_limit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [1:0]            unused_addr;

  assign unused_addr = addr[1:0];

  // Only RESULT writes while running have any effect.
  assign result_wr = wr_en && (addr[3:2] == tm_word(TM_RESULT_OFF)) && (state == TM_RUN);
  assign term_wr   = result_wr && wr_data[0];
  assign fail_wr   = result_wr && !wr_data[0] && (wr_data != '0);

`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] CYC_LIMIT = CNT_WIDTH'(MAX_CYCLES - 1);
  assign at_limit = (cycle_cnt == CYC_LIMIT);
`else
  assign at_limit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TM_RUN;
    end else begin
      state <= state_next;
    end
  end

  // A terminate write in the expiry cycle wins over the watchdog.
  always_comb begin
    state_next = state;
    done       = (state != TM_RUN);
    pass       = (state == TM_PASS);
`ifdef TEST_MONITOR_TIMEOUT_EN
    timeout    = (state == TM_TIMEOUT);
`else
    timeout    = 1'b0;
`endif
    if (state == TM_RUN) begin
      if (term_wr) begin
        state_next = ((wr_data[DATA_WIDTH-1:1] == '0) && (fail_count == '0)) ? TM_PASS : TM_FAIL;
      end else if (at_limit) begin
        state_next = TM_TIMEOUT;
      end
    end
  end

  // The counter only advances on edges that keep the monitor running, so it
  // freezes at the value it held in the cycle that ended the run.
  assign cyc_en = (state == TM_RUN) && (state_next == TM_RUN);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (cyc_en),
    .cnt (cycle_cnt)
  );

  sat_counter #(.WIDTH(FAIL_WIDTH)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (fail_wr),
    .cnt (fail_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exit_code <= '0;
    end else if (term_wr) begin
      exit_code <= wr_data[DATA_WIDTH-1:1];
    end
  end

  // Read mux sees pre-write state, so a simultaneous write is not reflected.
  always_comb begin
    rd_mux = '0;
    case (addr[3:2])
      tm_word(TM_FAIL_OFF):  rd_mux = DATA_WIDTH'(fail_count);
      tm_word(TM_CYCLE_OFF): rd_mux = DATA_WIDTH'(cycle_cnt);
      tm_word(TM_STATUS_OFF): begin
        rd_mux[TM_STAT_DONE_BIT]    = done;
        rd_mux[TM_STAT_PASS_BIT]    = pass;
        rd_mux[TM_STAT_TIMEOUT_BIT] = timeout;
        rd_mux[TM_STAT_STATE_MSB:TM_STAT_STATE_LSB] = state;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

endmodule
